uart_axis_tx: RTL and testbench

UART transmitter with an AXI-Stream slave input and a full `s_axis_ready` handshake. It serializes each accepted word into a standard asynchronous frame: start bit, data LSB first, optional parity, stop bit(s). It sits at the host side of the UART link and drives the serial line that the receiver path samples. It contains its own restartable bit-period counter and a one-entry holding buffer, so it can send frames back-to-back with no idle gap.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_baud_cnt.sv | 33 +++
 rtl/uart_axis_tx.sv | 148 ++++++++++++++
 tb/tb_uart_axis_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL      = 1'b1;
  localparam int   UART_DEFAULT_CLK_DIV = 868;

  // Width needed to count 0..n-1, never below one bit.
  function automatic int uart_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int UART_CNT_W = uart_width(UART_DEFAULT_CLK_DIV);
  localparam int UART_IDX_W = uart_width(9);

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// rtl/uart_tx_baud_cnt.sv - restartable bit-period counter with terminal-count tick
module uart_tx_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_DEFAULT_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic restart,
  output logic bit_done
);

  localparam int CNT_W = uart_width(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_done = (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d    = cnt_q + CNT_W'(1);
    if (restart || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_axis_tx.sv
// rtl/uart_axis_tx.sv - stream-fed UART transmitter with one-word holding buffer
// Optional even parity bit is compiled in with UART_TX_PARITY_EN.
module uart_axis_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = UART_DEFAULT_CLK_DIV,
  parameter int STOP_BITS  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  output logic                  o_tx,
  output logic                  o_busy
);

  localparam int IDX_W = uart_width(DATA_WIDTH);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif
  logic                  accept, load, restart, bit_done;

  uart_tx_baud_cnt #(.CLK_DIV(CLK_DIV)) u_baud (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .restart  (restart),
    .bit_done (bit_done)
  );

  assign s_axis_ready = i_rst && !hold_full_q;
  assign accept       = s_axis_valid && s_axis_ready;
  assign o_busy       = (state_q != ST_IDLE) || hold_full_q;
  assign o_tx         = tx_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    tx_d        = UART_IDLE_LEVEL;
    load        = 1'b0;
    restart     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        load = hold_full_q;
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_d = parity_q;
        if (bit_done) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            // A held word chains straight into the next start bit.
            load    = hold_full_q;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      state_d     = ST_START;
      idx_d       = '0;
      restart     = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d    = ^hold_q;
`endif
    end

    if (accept) begin
      hold_d      = s_axis_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      tx_q        <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_axis_tx.sv
// tb/tb_uart_axis_tx.sv - directed self-checking bench for uart_axis_tx
module tb_uart_axis_tx;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic       r0, tx0, b0, r1, tx1, b1;
  int         checks = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  uart_axis_tx #(.DATA_WIDTH(8), .CLK_DIV(DIV), .STOP_BITS(1)) dut (
    .i_clk(clk), .i_rst(rst_n), .s_axis_data(d0), .s_axis_valid(v0),
    .s_axis_ready(r0), .o_tx(tx0), .o_busy(b0)
  );

  uart_axis_tx #(.DATA_WIDTH(8), .CLK_DIV(DIV), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_rst(rst_n), .s_axis_data(d1), .s_axis_valid(v1),
    .s_axis_ready(r1), .o_tx(tx1), .o_busy(b1)
  );

  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int sb, output int n);
    logic [15:0] bits;
    int          idx;
    bits    = 16'hFFFF;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    idx = 9;
`ifdef UART_TX_PARITY_EN
    bits[9] = ^d;
    idx = 10;
`endif
    n = idx + sb;
    return bits;
  endfunction

  function automatic logic get_tx(input int which);
    return (which == 0) ? tx0 : tx1;
  endfunction

  function automatic logic get_busy(input int which);
    return (which == 0) ? b0 : b1;
  endfunction

  function automatic logic get_ready(input int which);
    return (which == 0) ? r0 : r1;
  endfunction

  task automatic set_in(input int which, input logic v, input logic [7:0] d);
    if (which == 0) begin
      v0 = v; d0 = d;
    end else begin
      v1 = v; d1 = d;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int which, output bit ok);
    int waitc = 0;
    while (get_ready(which) !== 1'b1 && waitc < 200) begin
      cycle();
      waitc++;
    end
    checks++;
    ok = (waitc < 200);
    if (!ok) begin
      fails++;
      $display("FAIL accept_timeout dut%0d: ready=%b after %0d cycles, required 1", which, get_ready(which), waitc);
    end
  endtask

  task automatic check_frame(input int which, input logic [7:0] d);
    logic [15:0] bits;
    int          n;
    bit          ok;
    bits = frame_bits(d, (which == 0) ? 1 : 2, n);
    set_in(which, 1'b1, d);
    wait_ready(which, ok);
    if (!ok) begin
      set_in(which, 1'b0, d);
      return;
    end
    cycle();
    set_in(which, 1'b0, d);
    checks++;
    if (get_busy(which) !== 1'b1) begin
      fails++; $display("FAIL busy_after_accept dut%0d data=%h: got %b, required 1", which, d, get_busy(which));
    end
    checks++;
    if (get_ready(which) !== 1'b0) begin
      fails++; $display("FAIL ready_after_accept dut%0d data=%h: got %b, required 0", which, d, get_ready(which));
    end
    cycle();
    checks++;
    if (get_tx(which) !== 1'b1) begin
      fails++; $display("FAIL tx_before_start dut%0d data=%h: got %b, required 1", which, d, get_tx(which));
    end
    for (int k = 0; k < n * DIV; k++) begin
      cycle();
      checks++;
      if (get_tx(which) !== bits[k/DIV]) begin
        fails++; $display("FAIL frame_tx dut%0d data=%h cycle=%0d: got %b, required %b", which, d, k, get_tx(which), bits[k/DIV]);
      end
      if (k == n * DIV - 2) begin
        checks++;
        if (get_busy(which) !== 1'b1) begin
          fails++; $display("FAIL busy_end_hold dut%0d data=%h: got %b, required 1", which, d, get_busy(which));
        end
      end
      if (k == n * DIV - 1) begin
        checks++;
        if (get_busy(which) !== 1'b0) begin
          fails++; $display("FAIL busy_end_drop dut%0d data=%h: got %b, required 0", which, d, get_busy(which));
        end
      end
    end
    cycle();
    checks++;
    if (get_tx(which) !== 1'b1 || get_busy(which) !== 1'b0) begin
      fails++; $display("FAIL idle_after_frame dut%0d data=%h: tx=%b busy=%b, required tx=1 busy=0", which, d, get_tx(which), get_busy(which));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (tx0 !== 1'b1 || b0 !== 1'b0 || r0 !== 1'b0) begin
        fails++; $display("FAIL reset_hold cycle=%0d: tx=%b busy=%b ready=%b, required 1 0 0", i, tx0, b0, r0);
      end
    end
    rst_n = 1'b1;
    cycle();
    checks++;
    if (tx0 !== 1'b1 || b0 !== 1'b0 || r0 !== 1'b1) begin
      fails++; $display("FAIL reset_release: tx=%b busy=%b ready=%b, required 1 0 1", tx0, b0, r0);
    end
  endtask

  task automatic test_single();
    check_frame(0, 8'hA5);
  endtask

  task automatic test_back_to_back();
    logic [15:0] f1, f2;
    int          n;
    bit          ok;
    f1 = frame_bits(8'h00, 1, n);
    f2 = frame_bits(8'hFF, 1, n);
    set_in(0, 1'b1, 8'h00);
    wait_ready(0, ok);
    if (!ok) begin
      set_in(0, 1'b0, 8'h00);
      return;
    end
    cycle();
    d0 = 8'hFF;
    checks++;
    if (r0 !== 1'b0) begin
      fails++; $display("FAIL b2b_ready_first_accept: got %b, required 0", r0);
    end
    cycle();
    checks++;
    if (r0 !== 1'b1) begin
      fails++; $display("FAIL b2b_ready_after_load: got %b, required 1", r0);
    end
    for (int k = 0; k < 2 * n * DIV; k++) begin
      cycle();
      if (k == 0) v0 = 1'b0;
      checks++;
      if (tx0 !== ((k < n * DIV) ? f1[k/DIV] : f2[(k - n*DIV)/DIV])) begin
        fails++; $display("FAIL b2b_tx cycle=%0d: got %b", k, tx0);
      end
      if (k < n * DIV) begin
        checks++;
        if (r0 !== ((k == n * DIV - 1) ? 1'b1 : 1'b0)) begin
          fails++; $display("FAIL b2b_ready cycle=%0d: got %b, required %b", k, r0, (k == n * DIV - 1));
        end
      end
      if (k >= 2 * n * DIV - 2) begin
        checks++;
        if (b0 !== ((k == 2 * n * DIV - 1) ? 1'b0 : 1'b1)) begin
          fails++; $display("FAIL b2b_busy cycle=%0d: got %b, required %b", k, b0, (k != 2 * n * DIV - 1));
        end
      end
    end
    cycle();
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    check_frame(0, 8'h07);
    check_frame(0, 8'h03);
  endtask
`endif

  task automatic test_reset_mid_frame();
    bit ok;
    set_in(0, 1'b1, 8'h5A);
    wait_ready(0, ok);
    if (!ok) begin
      set_in(0, 1'b0, 8'h5A);
      return;
    end
    cycle();
    v0 = 1'b0;
    cycle();
    for (int k = 0; k < 14; k++) cycle();
    checks++;
    if (tx0 !== 1'b0) begin
      fails++; $display("FAIL midreset_pre_tx: got %b, required 0", tx0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx0 !== 1'b1 || b0 !== 1'b0 || r0 !== 1'b0) begin
      fails++; $display("FAIL midreset_async: tx=%b busy=%b ready=%b, required 1 0 0", tx0, b0, r0);
    end
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    checks++;
    if (tx0 !== 1'b1 || b0 !== 1'b0 || r0 !== 1'b1) begin
      fails++; $display("FAIL midreset_release: tx=%b busy=%b ready=%b, required 1 0 1", tx0, b0, r0);
    end
    check_frame(0, 8'h3C);
  endtask

  task automatic test_stop_bits2();
    check_frame(1, 8'h81);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    test_stop_bits2();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
